// File: rtl/string_hw_pkg.sv
// +----------------------------------------------------------------------+
// | string_hw_pkg: shared word type, fetch FSM states, NUL-byte helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package string_hw_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  function automatic logic has_nul(input word_t w);
    logic z;
    z = 1'b0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (w[8*i +: 8] == 8'h00) z = 1'b1;
    end
    return z;
  endfunction
endpackage

`default_nettype wire

// File: rtl/string_word_fifo.sv
// +----------------------------------------------------------------------+
// | string_word_fifo: first-word fall-through word FIFO with occupancy.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module string_word_fifo
  import string_hw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  word_t                      push_data,
  input  logic                       pop,
  output word_t                      head,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

`default_nettype wire

// File: rtl/string_fetch_master.sv
// +----------------------------------------------------------------------+
// | string_fetch_master: Avalon-MM pipelined read master feeding a word  |
// | stream. Optional STRING_FETCH_NUL_STOP_EN stops at first NUL word.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module string_fetch_master
  import string_hw_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MAX_WORDS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_PEND   = 2,
  parameter int CNT_W      = $clog2(MAX_WORDS+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  word_t             avm_readdata,
  input  logic              avm_readdatavalid,
`ifdef STRING_FETCH_NUL_STOP_EN
  output logic              nul_hit,
`endif
  output word_t             out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int PEND_W = $clog2(MAX_PEND+1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);

  fetch_state_t      state;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  issued;
  logic [PEND_W-1:0] pending;
  logic [FCNT_W-1:0] fifo_count;

  logic              accept;
  logic              ret;
  logic              keep;
  logic              stop_hit;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  issued_nxt;
  logic [PEND_W-1:0] pending_nxt;
  logic [FCNT_W-1:0] fifo_nxt;
  logic              credit_nxt;
  logic [CNT_W-1:0]  count_sat;

  assign accept = avm_read & ~avm_waitrequest;
  assign ret    = avm_readdatavalid & (pending != '0);

`ifdef STRING_FETCH_NUL_STOP_EN
  assign keep     = ~nul_hit;
  assign stop_hit = ret & keep & has_nul(avm_readdata);
`else
  assign keep     = 1'b1;
  assign stop_hit = 1'b0;
`endif

  assign push        = ret & keep;
  assign pop         = out_valid & out_ready;
  assign issued_nxt  = issued + CNT_W'(accept);
  assign pending_nxt = pending + PEND_W'(accept) - PEND_W'(ret);
  assign fifo_nxt    = fifo_count + FCNT_W'(push) - FCNT_W'(pop);

  // Credit is judged on next-cycle occupancy, so a registered avm_read never overruns the FIFO.
  assign credit_nxt = (issued_nxt < total) &&
                      (32'(pending_nxt) < MAX_PEND) &&
                      (32'(pending_nxt) + 32'(fifo_nxt) < FIFO_DEPTH);
  assign count_sat  = (32'(word_count) > MAX_WORDS) ? CNT_W'(MAX_WORDS) : word_count;

  string_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (avm_readdata),
    .pop       (pop),
    .head      (out_data),
    .not_empty (out_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_address <= '0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      total       <= '0;
      issued      <= '0;
      pending     <= '0;
`ifdef STRING_FETCH_NUL_STOP_EN
      nul_hit     <= 1'b0;
`endif
    end else begin
      pending <= pending_nxt;
      issued  <= issued_nxt;
      if (accept) avm_address <= avm_address + ADDR_W'(4);
`ifdef STRING_FETCH_NUL_STOP_EN
      if (stop_hit) nul_hit <= 1'b1;
`endif
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef STRING_FETCH_NUL_STOP_EN
            nul_hit <= 1'b0;
`endif
            if (count_sat != '0) begin
              avm_address <= src_addr & ~ADDR_W'(3);
              total       <= count_sat;
              issued      <= '0;
              busy        <= 1'b1;
              avm_read    <= 1'b1;
              state       <= FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (avm_read && avm_waitrequest) begin
            // A stalled read stays posted; DRAIN drops it once accepted.
            if (stop_hit) state <= DRAIN;
          end else if (stop_hit || (issued_nxt == total)) begin
            avm_read <= 1'b0;
            state    <= DRAIN;
          end else begin
            avm_read <= credit_nxt;
          end
        end
        DRAIN: begin
          if (accept) begin
            avm_read <= 1'b0;
          end else if (!avm_read && (pending_nxt == '0) && (fifo_nxt == '0)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_string_fetch_master.sv
// +----------------------------------------------------------------------+
// | tb_string_fetch_master: Avalon slave model, stream scoreboard and    |
// | directed/random fetch sequence for string_fetch_master.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_string_fetch_master;
  localparam int MAX_WORDS  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_PEND   = 2;
  localparam int CNT_W      = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             busy, done, avm_read, out_valid;
  logic [31:0]      avm_address, out_data;
  logic             avm_waitrequest = 1'b0;
  logic [31:0]      avm_readdata = '0;
  logic             avm_readdatavalid = 1'b0;
  logic             out_ready = 1'b0;
`ifdef STRING_FETCH_NUL_STOP_EN
  logic             nul_hit;
  bit               nul_en = 1'b1;
`else
  bit               nul_en = 1'b0;
`endif

  string_fetch_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
`ifdef STRING_FETCH_NUL_STOP_EN
    .nul_hit(nul_hit),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Environment knobs and transaction model.
  int lat_lo = 1, lat_hi = 1, wr_pct = 0, ready_pct = 100;
  int stall_idx = -1, stall_len = 0, stall_left = 0;
  bit stalled_once = 1'b0, inject_rdv = 1'b0;
  bit ovr_en = 1'b0;
  logic [31:0] ovr_base = '0;
  logic [31:0] ovr [3];
  logic [31:0] base = '0;
  int tot_exp = 0, exp_len = 0, acc_idx = 0, ret_idx = 0, occ = 0, popped = 0;
  int last_due = 0, last_pop_cyc = 0, lat, due;
  bit exp_nul = 1'b0;
  logic [31:0] exp_q [$];
  int          due_q [$];
  logic [31:0] rdata_q [$];
  bit prev_stall = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic bit has_zero(input logic [31:0] w);
    return ((w & 32'h0000_00FF) == 0) || ((w & 32'h0000_FF00) == 0) ||
           ((w & 32'h00FF_0000) == 0) || ((w & 32'hFF00_0000) == 0);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - ovr_base;
    if (ovr_en && off < 12) return ovr[off[3:2]];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Slave, consumer and stream monitor; all decisions are made for the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      prev_stall        = 1'b0;
      prev_done         = 1'b0;
    end else begin
      chk("pend_limit", 32'(due_q.size() <= MAX_PEND), 1);
      chk("credit_limit", 32'(due_q.size() + occ <= FIFO_DEPTH), 1);
      chk("out_valid", out_valid, 32'(occ != 0));
      if (prev_done) chk("done_pulse", done, 0);
      if (prev_stall) begin
        chk("stall_hold_read", avm_read, 1);
        chk("stall_hold_addr", avm_address, prev_addr);
      end
      prev_done = done;

      avm_readdatavalid = 1'b0;
      if (inject_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        inject_rdv        = 1'b0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
        void'(due_q.pop_front());
        avm_readdata      = rdata_q.pop_front();
        avm_readdatavalid = 1'b1;
        if (ret_idx < exp_len) occ++;
        ret_idx++;
      end

      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", out_data, 32'hFFFF_FFFF);
        else chk("out_data", out_data, exp_q.pop_front());
        occ--;
        popped++;
        last_pop_cyc = cyc;
      end

      if (avm_read) begin
        if (stall_left == 0 && acc_idx == stall_idx && !stalled_once) begin
          stall_left   = stall_len;
          stalled_once = 1'b1;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          chk("stall_addr", avm_address, base + 32'(4 * acc_idx));
        end else begin
          avm_waitrequest = ($urandom_range(99) < wr_pct);
        end
        if (!avm_waitrequest) begin
          chk("rd_addr", avm_address, base + 32'(4 * acc_idx));
          chk("rd_in_range", 32'(acc_idx < tot_exp), 1);
          lat = int'($urandom_range(lat_hi, lat_lo));
          due = cyc + 1 + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          due_q.push_back(due);
          rdata_q.push_back(mem_rd(base + 32'(4 * acc_idx)));
          acc_idx++;
        end
      end else begin
        avm_waitrequest = 1'($urandom_range(1));
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
    end
  end

  task automatic launch(input logic [31:0] a, input int cnt);
    logic [31:0] w;
    tot_exp = (cnt > MAX_WORDS) ? MAX_WORDS : cnt;
    base    = a & 32'hFFFF_FFFC;
    exp_q.delete();
    acc_idx = 0; ret_idx = 0; popped = 0; stalled_once = 1'b0;
    for (int i = 0; i < tot_exp; i++) begin
      w = mem_rd(base + 32'(4 * i));
      exp_q.push_back(w);
      if (nul_en && has_zero(w)) break;
    end
    exp_len = exp_q.size();
    exp_nul = nul_en && exp_len > 0 && has_zero(exp_q[exp_len-1]);
    @(negedge clk);
    start = 1'b1; src_addr = a; word_count = cnt[CNT_W-1:0];
    @(negedge clk);
    start = 1'b0;
    if (tot_exp != 0) begin
      chk("busy_rise", busy, 1);
    end else begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_no_timeout"}, 32'(k < limit), 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_words_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_popped"}, 32'(popped), 32'(exp_len));
    if (!nul_en) chk({tag, "_accepts"}, 32'(acc_idx), 32'(tot_exp));
    if (exp_len > 0 && !exp_nul) chk({tag, "_done_latency"}, 32'(cyc - last_pop_cyc), 1);
`ifdef STRING_FETCH_NUL_STOP_EN
    chk({tag, "_nul_hit"}, nul_hit, 32'(exp_nul));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_valid", out_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic fetch with single-cycle latency and no stalls.
    launch(32'h0000_0100, 4);
    wait_done("basic", 100);

    // Three-cycle stall on the second read.
    stall_idx = 1; stall_len = 3;
    launch(32'h0000_0200, 4);
    wait_done("stall", 100);
    chk("stall_seen", 32'(stalled_once), 1);
    stall_idx = -1;

    // Backpressure: consumer stalled, then released.
    ready_pct = 0; lat_hi = 2;
    launch(32'h0000_0400, 8);
    repeat (30) @(negedge clk);
    chk("bp_accepts", 32'(acc_idx), 4);
    chk("bp_valid", out_valid, 1);
    ready_pct = 100;
    wait_done("bp", 200);

    // Zero count: immediate done, no reads.
    launch(32'h0000_0600, 0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_no_read", avm_read, 0);
    end
    chk("zero_accepts", 32'(acc_idx), 0);

    // Address wrap, unaligned source, saturated count.
    launch(32'hFFFF_FFF9, 4);
    wait_done("wrap", 100);
    launch(32'h0000_0503, 20);
    wait_done("sat", 300);

    // Start pulsed mid-fetch is ignored.
    ready_pct = 50;
    launch(32'h0000_0800, 8);
    repeat (3) @(negedge clk);
    start = 1'b1; src_addr = 32'h0000_9000; word_count = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 300);
    ready_pct = 100;

    // Randomized transfers.
    for (int t = 0; t < 25; t++) begin
      lat_lo = 1; lat_hi = int'($urandom_range(3, 1));
      wr_pct = int'($urandom_range(40));
      ready_pct = int'($urandom_range(100, 30));
      launch($urandom, int'($urandom_range(20)));
      if (tot_exp > 0) wait_done("rand", 600);
    end

`ifdef STRING_FETCH_NUL_STOP_EN
    // NUL terminator in the second word.
    ovr_en = 1'b1; ovr_base = 32'h0000_0300;
    ovr[0] = 32'h4142_4344; ovr[1] = 32'h4546_0000; ovr[2] = 32'h4748_4950;
    lat_lo = 2; lat_hi = 2; wr_pct = 0; ready_pct = 100;
    launch(32'h0000_0300, 3);
    wait_done("nul", 100);
    chk("nul_words", 32'(popped), 2);
    chk("nul_flag", nul_hit, 1);
    ovr_en = 1'b0;
`endif

    // Reset with two reads outstanding.
    lat_lo = 3; lat_hi = 3; wr_pct = 0; ready_pct = 0;
    launch(32'h0000_2000, 8);
    k = 0;
    while (!(due_q.size() == 2 && avm_read == 1'b0) && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rst_mid_pend2", 32'(due_q.size()), 2);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_read", avm_read, 0);
    chk("arst_addr", avm_address, 0);
    chk("arst_valid", out_valid, 0);
    due_q.delete(); rdata_q.delete(); exp_q.delete();
    occ = 0; exp_len = 0; last_due = 0; ready_pct = 100;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    inject_rdv = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_rdv_ignored", out_valid, 0);
    chk("late_rdv_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/string_fetch_master.md
Name: string_fetch_master

Overview:
- Avalon-MM read master that fetches a NUL-padded string, packed four bytes per word, from memory.
- Buffers the fetched words in a small FIFO and presents them on a valid/ready word stream.
- Sits on the initiator side of the string hardware accelerator. Software (or a sequencer) supplies source address and word count; the block feeds words to the accelerator's A/B operand loaders without CPU register writes.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- MAX_WORDS, 16, largest word_count accepted. Count width CNT_W = $clog2(MAX_WORDS+1).
- FIFO_DEPTH, 4, entries in the internal word FIFO. Power of two, at least 2.
- MAX_PEND, 2, maximum outstanding (accepted but unreturned) Avalon reads.

Ports:
- clk, input, 1, system clock. All logic rises on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a fetch. Sampled only in IDLE.
- src_addr, input, ADDR_W, byte address of the first word. Bits [1:0] are forced to 0 when latched.
- word_count, input, CNT_W, number of 32-bit words to fetch. Values above MAX_WORDS saturate to MAX_WORDS.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when the fetch is complete and the FIFO has drained.
- avm_address, output, ADDR_W, Avalon read address.
- avm_read, output, 1, Avalon read strobe.
- avm_waitrequest, input, 1, slave stall.
- avm_readdata, input, 32, returned word.
- avm_readdatavalid, input, 1, marks avm_readdata valid (pipelined reads).
- out_data, output, 32, head-of-FIFO word.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts out_data this cycle.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - busy=0, done=0, avm_read=0, avm_address=0, out_valid=0.
  - FIFO pointers, pending, issued and remaining counters cleared; state=IDLE.
  - Reset mid-fetch abandons the transfer. Late readdatavalid arriving after reset release is ignored because pending=0.
- States:
  - IDLE:
    - start with word_count!=0: latch address, set remaining=count, go to FETCH next cycle.
    - start with word_count==0: done pulses the next cycle; stay in IDLE; busy never rises.
  - FETCH:
    - Issue condition: issued<count AND pending<MAX_PEND AND pending+fifo_count<FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
    - When the issue condition holds, assert avm_read.
    - Avalon rule: while avm_read=1 and avm_waitrequest=1, avm_read and avm_address hold stable. Drop of the credit cannot retract a posted read.
    - On acceptance (avm_read & !avm_waitrequest):
      - avm_address += 4, wrapping modulo 2^ADDR_W.
      - issued++; pending++.
      - avm_read may remain high for back-to-back issue if credit allows.
    - When issued==count after an acceptance: deassert avm_read, go to DRAIN.
  - DRAIN: wait until pending==0 AND FIFO empty, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle; return to IDLE. start is ignored in DONE.
- Read return:
  - avm_readdatavalid pushes avm_readdata into the FIFO and decrements pending.
  - Acceptance and readdatavalid in the same cycle leave pending unchanged.
  - readdatavalid with pending==0 is ignored, with no push.
- FIFO:
  - First-word fall-through. out_valid rises the cycle after the readdatavalid that fills an empty FIFO (1-cycle latency).
  - Pop occurs on out_valid & out_ready. out_ready with FIFO empty is ignored.
  - Simultaneous push and pop leaves the count unchanged; legal at full.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: words leave in address order; returns are in-order per Avalon pipelined semantics.
- start while busy is ignored.

Optional Feature:
- Macro: STRING_FETCH_NUL_STOP_EN.
- When defined:
  - Every returned word is checked for any zero byte.
  - The first such word is pushed, then issue stops immediately and the state goes to DRAIN.
  - Reads already outstanding still decrement pending but are discarded, not pushed.
  - The status output nul_hit (1 bit) is added: set with the terminating push, cleared on the next accepted start, reset value 0.
- When undefined: exactly word_count words are fetched, with no byte inspection and no nul_hit port.

Decomposition:
- Shared package string_hw_pkg:
  - WORD_W=32, BYTES_PER_WORD=4.
  - Typedef word_t (logic [31:0]).
  - Enum fetch_state_t {IDLE, FETCH, DRAIN, DONE}.
  - Function has_nul(word_t).
- One sub-module: string_word_fifo (parameterized FIFO_DEPTH, FWFT, exports count).
- The credit and FSM logic stay in string_fetch_master.

Test Plan:
- Basic fetch:
  - Stimulus: src_addr=0x100, count=4, waitrequest=0, 1-cycle read latency, out_ready=1.
  - Response: addresses 0x100,0x104,0x108,0x10C, each once; 4 words out in order; done one cycle after the last pop; busy low with done.
- Waitrequest stall:
  - Stimulus: hold waitrequest=1 for 3 cycles on the 2nd read.
  - Response: avm_address=0x104 and avm_read=1 stable across the stall; no duplicate or skipped address.
- Backpressure:
  - Stimulus: out_ready=0, count=8, FIFO_DEPTH=4.
  - Response: at most 4 reads accepted; pending+fifo_count<=4 every cycle; releasing out_ready drains all 8 words in order.
- Zero count and busy start:
  - Stimulus: start with count=0.
  - Response: done on the next cycle, busy stays 0, no avm_read.
  - Stimulus: start pulsed mid-fetch.
  - Response: ignored.
- Reset mid-fetch:
  - Stimulus: reset_n low during FETCH with 2 reads pending.
  - Response: all outputs return to reset values asynchronously; a readdatavalid after release is not pushed.
- NUL stop (STRING_FETCH_NUL_STOP_EN):
  - Stimulus: memory words 0x41424344, 0x45460000, 0x47484950; count=3.
  - Response: exactly 2 words emitted; nul_hit=1; any outstanding 3rd return is discarded; done pulses.
